// File: rtl/arp_pkg.sv
// Shared ARP constants, frame-kind enum and the 60-byte frame builder.
package arp_pkg;

    localparam int unsigned ARP_PKT_LEN = 60;
    localparam int unsigned ARP_FRAME_W = ARP_PKT_LEN * 8;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  HLEN_ETH     = 8'h06;
    localparam logic [7:0]  PLEN_IPV4    = 8'h04;
    localparam logic [15:0] OPER_REQ     = 16'h0001;
    localparam logic [15:0] OPER_REP     = 16'h0002;

    // Byte offsets within the frame (byte 0 is the first byte on the wire)
    localparam int unsigned OFF_DA    = 0;
    localparam int unsigned OFF_SA    = 6;
    localparam int unsigned OFF_ETYPE = 12;
    localparam int unsigned OFF_HTYPE = 14;
    localparam int unsigned OFF_PTYPE = 16;
    localparam int unsigned OFF_HLEN  = 18;
    localparam int unsigned OFF_PLEN  = 19;
    localparam int unsigned OFF_OPER  = 20;
    localparam int unsigned OFF_SHA   = 22;
    localparam int unsigned OFF_SPA   = 28;
    localparam int unsigned OFF_THA   = 32;
    localparam int unsigned OFF_TPA   = 38;

    typedef enum logic [1:0] {
        ARP_REPLY   = 2'd0,
        ARP_REQUEST = 2'd1,
        ARP_GARP    = 2'd2
    } arp_kind_e;

    // Little-endian packing: byte n lands on bits [8n+7:8n]; fields are big-endian on the wire.
    function automatic logic [ARP_FRAME_W-1:0] arp_build_frame(
        input arp_kind_e   kind,
        input logic [47:0] eff_mac,
        input logic [31:0] eff_ip,
        input logic [47:0] peer_mac,
        input logic [31:0] peer_ip
    );
        logic [ARP_FRAME_W-1:0] f;
        logic [47:0]            da;
        logic [47:0]            tha;
        logic [15:0]            oper;
        logic [31:0]            tpa;
        case (kind)
            ARP_REPLY: begin
                da   = peer_mac;
                tha  = peer_mac;
                oper = OPER_REP;
                tpa  = peer_ip;
            end
            ARP_REQUEST: begin
                da   = '1;
                tha  = '0;
                oper = OPER_REQ;
                tpa  = peer_ip;
            end
            default: begin
                da   = '1;
                tha  = '0;
                oper = OPER_REQ;
                tpa  = eff_ip;
            end
        endcase
        f = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            f[8*(OFF_DA+i)  +: 8] = da[8*(5-i)      +: 8];
            f[8*(OFF_SA+i)  +: 8] = eff_mac[8*(5-i) +: 8];
            f[8*(OFF_SHA+i) +: 8] = eff_mac[8*(5-i) +: 8];
            f[8*(OFF_THA+i) +: 8] = tha[8*(5-i)     +: 8];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            f[8*(OFF_SPA+i) +: 8] = eff_ip[8*(3-i) +: 8];
            f[8*(OFF_TPA+i) +: 8] = tpa[8*(3-i)    +: 8];
        end
        for (int unsigned i = 0; i < 2; i++) begin
            f[8*(OFF_ETYPE+i) +: 8] = ETH_TYPE_ARP[8*(1-i) +: 8];
            f[8*(OFF_HTYPE+i) +: 8] = HTYPE_ETH[8*(1-i)    +: 8];
            f[8*(OFF_PTYPE+i) +: 8] = PTYPE_IPV4[8*(1-i)   +: 8];
            f[8*(OFF_OPER+i)  +: 8] = oper[8*(1-i)         +: 8];
        end
        f[8*OFF_HLEN +: 8] = HLEN_ETH;
        f[8*OFF_PLEN +: 8] = PLEN_IPV4;
        return f;
    endfunction

endpackage

// File: rtl/arp_tx_mc_reply_fifo.sv
// Pending-reply queue: {mac, ip} entries, accepts a push into a full queue when popped same cycle.
module arp_reply_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 80
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_q];

    // Occupancy bookkeeping
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/arp_tx_mc.sv
// ARP reply / request / gratuitous frame transmitter onto an AXI4-Stream master.
module arp_tx_mc
    import arp_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM       = 0,
    parameter int unsigned C_AXIS_DATA_WIDTH = 512,
    parameter int unsigned REPLY_FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [47:0]                    cfg_local_mac,
    input  logic [31:0]                    cfg_local_ip,
    input  logic                           rx_req_valid,
    input  logic [47:0]                    rx_req_mac,
    input  logic [31:0]                    rx_req_ip,
    input  logic                           tx_req_valid,
    input  logic [31:0]                    tx_req_ip,
    output logic                           tx_req_ready,
    input  logic                           garp_trig,
    output logic [C_AXIS_DATA_WIDTH-1:0]   tx_m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] tx_m_axis_tkeep,
    output logic                           tx_m_axis_tvalid,
    output logic                           tx_m_axis_tlast,
    input  logic                           tx_m_axis_tready,
    output logic                           arp_tx_done,
    output logic [1:0]                     arp_tx_kind,
    output logic [15:0]                    reply_drop_cnt
);

    localparam int unsigned W          = C_AXIS_DATA_WIDTH;
    localparam int unsigned KW         = W / 8;
    localparam int unsigned NBEATS     = (ARP_PKT_LEN + KW - 1) / KW;
    localparam int unsigned LAST_BYTES = ARP_PKT_LEN - (NBEATS - 1) * KW;
    localparam int unsigned BW         = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned PAD_W      = NBEATS * W;

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e      state_q, state_d;
    arp_kind_e   sel_kind, kind_q;
    logic        lwr_q, lwr_d;
    logic        garp_pend_q;
    logic        garp_clr;
    logic        load;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;
    logic [79:0] fifo_data;
    logic [47:0] eff_mac;
    logic [31:0] eff_ip;
    logic [31:0] peer_ip;
    logic [PAD_W-1:0] frame_q;
    logic [BW-1:0]    beat_q;
    logic             last_beat;
    logic             beat_fire;
    logic [15:0]      drop_cnt_q;

    assign eff_mac   = cfg_local_mac + 48'(CHANNEL_NUM);
    assign eff_ip    = cfg_local_ip + 32'(CHANNEL_NUM);
    assign peer_ip   = (sel_kind == ARP_REQUEST) ? tx_req_ip : fifo_data[31:0];
    assign last_beat = (beat_q == BW'(NBEATS - 1));
    assign beat_fire = (state_q == StSend) && tx_m_axis_tready;
    assign fifo_drop = rx_req_valid && fifo_full && !fifo_pop;

    arp_reply_fifo #(
        .DEPTH (REPLY_FIFO_DEPTH),
        .WIDTH (80)
    ) u_reply_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_req_valid),
        .push_data ({rx_req_mac, rx_req_ip}),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Source arbitration, FSM next state and handshake outputs
    always_comb begin
        state_d          = state_q;
        lwr_d            = lwr_q;
        sel_kind         = ARP_REPLY;
        load             = 1'b0;
        fifo_pop         = 1'b0;
        garp_clr         = 1'b0;
        tx_req_ready     = 1'b0;
        tx_m_axis_tvalid = 1'b0;
        tx_m_axis_tlast  = 1'b0;
        arp_tx_done      = 1'b0;
        arp_tx_kind      = 2'd0;
        unique case (state_q)
            StIdle: begin
                // Alternate replies with host requests so neither source starves
                if (!fifo_empty && (!tx_req_valid || !lwr_q)) begin
                    sel_kind = ARP_REPLY;
                    fifo_pop = 1'b1;
                    lwr_d    = 1'b1;
                    load     = 1'b1;
                end else if (tx_req_valid) begin
                    sel_kind     = ARP_REQUEST;
                    tx_req_ready = 1'b1;
                    lwr_d        = 1'b0;
                    load         = 1'b1;
                end else if (garp_pend_q) begin
                    sel_kind = ARP_GARP;
                    garp_clr = 1'b1;
                    load     = 1'b1;
                end
                if (load) state_d = StSend;
            end
            StSend: begin
                tx_m_axis_tvalid = 1'b1;
                tx_m_axis_tlast  = last_beat;
                if (tx_m_axis_tready && last_beat) state_d = StDone;
            end
            StDone: begin
                arp_tx_done = 1'b1;
                arp_tx_kind = kind_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat data and byte enables; only the final beat is partially filled
    always_comb begin
        tx_m_axis_tdata = (state_q == StSend) ? frame_q[W-1:0] : '0;
        tx_m_axis_tkeep = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            tx_m_axis_tkeep[i] = (state_q == StSend) && (!last_beat || (i < LAST_BYTES));
        end
    end

    // Control state: FSM, arbitration history, pending gratuitous flag, drop counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            lwr_q       <= 1'b0;
            garp_pend_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lwr_q       <= lwr_d;
            garp_pend_q <= (garp_pend_q && !garp_clr) || garp_trig;
            if (fifo_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    // Frame register: snapshot on selection, shift down one beat per accepted beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_q <= '0;
            beat_q  <= '0;
            kind_q  <= ARP_REPLY;
        end else if (load) begin
            frame_q <= PAD_W'(arp_build_frame(sel_kind, eff_mac, eff_ip, fifo_data[79:32],
                                              peer_ip));
            beat_q  <= '0;
            kind_q  <= sel_kind;
        end else if (beat_fire) begin
            frame_q <= frame_q >> W;
            beat_q  <= beat_q + 1'b1;
        end
    end

    assign reply_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_arp_tx_mc.sv
// Directed bench for arp_tx_mc at 512-, 64- and 256-bit stream widths.
module tb_arp_tx_mc;

    logic        clk = 1'b0;
    logic        rstn;
    logic [47:0] cfg_local_mac = 48'h000A35000010;
    logic [31:0] cfg_local_ip  = 32'hC0A8010A;
    logic        rx_req_valid;
    logic [47:0] rx_req_mac;
    logic [31:0] rx_req_ip;
    logic        tx_req_valid;
    logic [31:0] tx_req_ip;
    logic        garp_trig;
    logic        tready;

    logic [511:0] d512; logic [63:0] k512; logic v512, l512, done512, rdy512;
    logic [1:0] kind512; logic [15:0] drop512;
    logic [63:0]  d64;  logic [7:0]  k64;  logic v64, l64, done64, rdy64;
    logic [1:0] kind64; logic [15:0] drop64;
    logic [255:0] d256; logic [31:0] k256; logic v256, l256, done256, rdy256;
    logic [1:0] kind256; logic [15:0] drop256;

    int errors = 0;
    int checks = 0;
    int ready_cnt;
    bit req_drop_pend;

    always #5 clk = ~clk;

    arp_tx_mc #(.CHANNEL_NUM(1), .C_AXIS_DATA_WIDTH(512), .REPLY_FIFO_DEPTH(4)) u512 (
        .clk(clk), .rstn(rstn), .cfg_local_mac(cfg_local_mac), .cfg_local_ip(cfg_local_ip),
        .rx_req_valid(rx_req_valid), .rx_req_mac(rx_req_mac), .rx_req_ip(rx_req_ip),
        .tx_req_valid(tx_req_valid), .tx_req_ip(tx_req_ip), .tx_req_ready(rdy512),
        .garp_trig(garp_trig), .tx_m_axis_tdata(d512), .tx_m_axis_tkeep(k512),
        .tx_m_axis_tvalid(v512), .tx_m_axis_tlast(l512), .tx_m_axis_tready(tready),
        .arp_tx_done(done512), .arp_tx_kind(kind512), .reply_drop_cnt(drop512));

    arp_tx_mc #(.CHANNEL_NUM(1), .C_AXIS_DATA_WIDTH(64), .REPLY_FIFO_DEPTH(4)) u64 (
        .clk(clk), .rstn(rstn), .cfg_local_mac(cfg_local_mac), .cfg_local_ip(cfg_local_ip),
        .rx_req_valid(rx_req_valid), .rx_req_mac(rx_req_mac), .rx_req_ip(rx_req_ip),
        .tx_req_valid(tx_req_valid), .tx_req_ip(tx_req_ip), .tx_req_ready(rdy64),
        .garp_trig(garp_trig), .tx_m_axis_tdata(d64), .tx_m_axis_tkeep(k64),
        .tx_m_axis_tvalid(v64), .tx_m_axis_tlast(l64), .tx_m_axis_tready(tready),
        .arp_tx_done(done64), .arp_tx_kind(kind64), .reply_drop_cnt(drop64));

    arp_tx_mc #(.CHANNEL_NUM(1), .C_AXIS_DATA_WIDTH(256), .REPLY_FIFO_DEPTH(4)) u256 (
        .clk(clk), .rstn(rstn), .cfg_local_mac(cfg_local_mac), .cfg_local_ip(cfg_local_ip),
        .rx_req_valid(rx_req_valid), .rx_req_mac(rx_req_mac), .rx_req_ip(rx_req_ip),
        .tx_req_valid(tx_req_valid), .tx_req_ip(tx_req_ip), .tx_req_ready(rdy256),
        .garp_trig(garp_trig), .tx_m_axis_tdata(d256), .tx_m_axis_tkeep(k256),
        .tx_m_axis_tvalid(v256), .tx_m_axis_tlast(l256), .tx_m_axis_tready(tready),
        .arp_tx_done(done256), .arp_tx_kind(kind256), .reply_drop_cnt(drop256));

    // Expected frame; effective MAC 00:0A:35:00:00:11 and IP C0A8010B with CHANNEL_NUM=1
    function automatic logic [479:0] exp_frame(input logic [47:0] da, input logic [15:0] oper,
                                               input logic [47:0] tha, input logic [31:0] tpa);
        logic [7:0]   b [60];
        logic [479:0] f;
        logic [47:0]  sa;
        logic [31:0]  spa;
        sa  = 48'h000A35000011;
        spa = 32'hC0A8010B;
        for (int i = 0; i < 60; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = da[47-8*i -: 8];
            b[6+i]    = sa[47-8*i -: 8];
            b[22+i]   = sa[47-8*i -: 8];
            b[32+i]   = tha[47-8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
        b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
        b[20] = oper[15:8]; b[21] = oper[7:0];
        for (int i = 0; i < 4; i++) begin
            b[28+i] = spa[31-8*i -: 8];
            b[38+i] = tpa[31-8*i -: 8];
        end
        for (int i = 0; i < 60; i++) f[8*i +: 8] = b[i];
        return f;
    endfunction

    task automatic do_reset();
        rstn = 1'b0; rx_req_valid = 1'b0; rx_req_mac = '0; rx_req_ip = '0;
        tx_req_valid = 1'b0; tx_req_ip = '0; garp_trig = 1'b0; tready = 1'b0;
        req_drop_pend = 1'b0; ready_cnt = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_rx(input logic [47:0] mac, input logic [31:0] ip);
        rx_req_valid = 1'b1; rx_req_mac = mac; rx_req_ip = ip;
        @(negedge clk);
        rx_req_valid = 1'b0;
    endtask

    // Collects one 512-bit frame up to its done pulse; also releases a host request once accepted
    task automatic get_frame512(output logic [511:0] d, output logic [1:0] kind, output bit ok);
        ok = 1'b0; d = '0; kind = 2'd3;
        for (int c = 0; c < 60; c++) begin
            if (req_drop_pend) begin tx_req_valid = 1'b0; req_drop_pend = 1'b0; end
            #1;
            if (tx_req_valid && rdy512) begin ready_cnt++; req_drop_pend = 1'b1; end
            if (v512 && tready) d = d512;
            if (done512) begin
                kind = kind512; ok = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({v512, v64, v256} !== 3'b000) begin errors++;
            $display("FAIL reset_tvalid: got %b want 000", {v512, v64, v256}); end
        checks++; if ({done512, done64, done256, rdy512} !== 4'b0000) begin errors++;
            $display("FAIL reset_done_ready: got %b want 0000", {done512, done64, done256, rdy512}); end
        checks++; if ({drop512, kind512, l512} !== 19'd0 || d512 !== '0 || k512 !== '0) begin errors++;
            $display("FAIL reset_outputs: drop %h kind %h last %b keep %h", drop512, kind512, l512, k512); end
    endtask

    task automatic test_reply_512();
        logic [479:0] ef;
        do_reset();
        tready = 1'b1;
        pulse_rx(48'h112233445566, 32'hC0A80102);
        @(negedge clk);
        ef = exp_frame(48'h112233445566, 16'h0002, 48'h112233445566, 32'hC0A80102);
        checks++; if (v512 !== 1'b1 || l512 !== 1'b1) begin errors++;
            $display("FAIL reply512_valid_last: got %b%b want 11", v512, l512); end
        checks++; if (d512 !== {32'h0, ef}) begin errors++;
            $display("FAIL reply512_data: got %h want %h", d512, {32'h0, ef}); end
        checks++; if (d512[8*28 +: 32] !== 32'h0B01A8C0) begin errors++;
            $display("FAIL reply512_spa: got %h want 0b01a8c0", d512[8*28 +: 32]); end
        checks++; if (k512 !== 64'h0FFF_FFFF_FFFF_FFFF) begin errors++;
            $display("FAIL reply512_keep: got %h want 0fffffffffffffff", k512); end
        @(negedge clk);
        checks++; if (done512 !== 1'b1 || kind512 !== 2'd0 || v512 !== 1'b0) begin errors++;
            $display("FAIL reply512_done: got done %b kind %0d valid %b want 1 0 0", done512, kind512, v512); end
        @(negedge clk);
        checks++; if (done512 !== 1'b0) begin errors++;
            $display("FAIL reply512_done_width: got %b want 0", done512); end
    endtask

    task automatic test_request_64();
        logic [511:0] got;
        logic [479:0] ef;
        logic [63:0]  prev_d;
        logic [8:0]   prev_kl;
        bit           have_prev;
        bit           finished;
        int           beat;
        do_reset();
        tready = 1'b1; tx_req_ip = 32'hC0A80105; tx_req_valid = 1'b1;
        #1;
        checks++; if (rdy64 !== 1'b1) begin errors++;
            $display("FAIL req64_ready: got %b want 1", rdy64); end
        @(negedge clk);
        tx_req_valid = 1'b0;
        got = '0; beat = 0; have_prev = 1'b0; finished = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            tready = (c % 2 == 0);
            #1;
            if (have_prev) begin
                checks++; if (d64 !== prev_d || {k64, l64} !== prev_kl || v64 !== 1'b1) begin errors++;
                    $display("FAIL req64_stall_stable: got %h/%h want %h/%h", d64, {k64, l64}, prev_d, prev_kl); end
                have_prev = 1'b0;
            end
            if (done64) begin
                finished = 1'b1;
                checks++; if (beat != 8 || kind64 !== 2'd1) begin errors++;
                    $display("FAIL req64_done: got beats %0d kind %0d want 8 1", beat, kind64); end
            end else if (v64 && tready) begin
                checks++; if (k64 !== ((beat == 7) ? 8'h0F : 8'hFF) || l64 !== (beat == 7)) begin errors++;
                    $display("FAIL req64_keep_last beat %0d: got %h %b", beat, k64, l64); end
                if (beat == 0) begin
                    checks++; if (d64 !== 64'h0A00_FFFF_FFFF_FFFF) begin errors++;
                        $display("FAIL req64_beat0: got %h want 0a00ffffffffffff", d64); end
                end
                if (beat < 8) got[64*beat +: 64] = d64;
                beat++;
            end else if (v64) begin
                prev_d = d64; prev_kl = {k64, l64}; have_prev = 1'b1;
            end
            @(negedge clk);
        end
        checks++; if (!finished) begin errors++;
            $display("FAIL req64_timeout: got no done want done"); end
        ef = exp_frame(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'hC0A80105);
        checks++; if (got[479:0] !== ef) begin errors++;
            $display("FAIL req64_frame: got %h want %h", got[479:0], ef); end
        tready = 1'b1;
    endtask

    task automatic test_fifo_overflow();
        logic [511:0] d; logic [1:0] k; bit ok;
        logic [479:0] ef;
        do_reset();
        garp_trig = 1'b1;
        @(negedge clk);
        garp_trig = 1'b0;
        for (int i = 0; i < 6; i++) pulse_rx({40'h0200000000, 8'(i)}, 32'hC0A80110 + 32'(i));
        #1;
        checks++; if (drop512 !== 16'd2) begin errors++;
            $display("FAIL ovf_drop_cnt: got %0d want 2", drop512); end
        tready = 1'b1;
        get_frame512(d, k, ok);
        checks++; if (!ok || k !== 2'd2) begin errors++;
            $display("FAIL ovf_first_garp: got ok %b kind %0d want 1 2", ok, k); end
        for (int i = 0; i < 4; i++) begin
            get_frame512(d, k, ok);
            ef = exp_frame({40'h0200000000, 8'(i)}, 16'h0002, {40'h0200000000, 8'(i)},
                           32'hC0A80110 + 32'(i));
            checks++; if (!ok || k !== 2'd0 || d[479:0] !== ef) begin errors++;
                $display("FAIL ovf_reply%0d: got ok %b kind %0d da %h", i, ok, k, d[47:0]); end
        end
        checks++; if (drop512 !== 16'd2) begin errors++;
            $display("FAIL ovf_drop_hold: got %0d want 2", drop512); end
    endtask

    task automatic test_fairness();
        logic [511:0] d; logic [1:0] k; bit ok;
        logic [1:0] exp_k [5];
        int         rep;
        exp_k[0] = 2'd2; exp_k[1] = 2'd0; exp_k[2] = 2'd1; exp_k[3] = 2'd0; exp_k[4] = 2'd0;
        do_reset();
        garp_trig = 1'b1;
        @(negedge clk);
        garp_trig = 1'b0;
        for (int i = 0; i < 3; i++) pulse_rx({40'h0300000000, 8'(i)}, 32'hC0A80120 + 32'(i));
        tx_req_ip = 32'hC0A80105; tx_req_valid = 1'b1;
        tready = 1'b1;
        rep = 0;
        for (int f = 0; f < 5; f++) begin
            get_frame512(d, k, ok);
            checks++; if (!ok || k !== exp_k[f]) begin errors++;
                $display("FAIL fair_order%0d: got ok %b kind %0d want %0d", f, ok, k, exp_k[f]); end
            if (ok && k == 2'd0) begin
                checks++; if (d[47:0] !== {8'(rep), 40'h0000000003}) begin errors++;
                    $display("FAIL fair_reply_da%0d: got %h", rep, d[47:0]); end
                rep++;
            end
        end
        tx_req_valid = 1'b0;
        checks++; if (ready_cnt != 1) begin errors++;
            $display("FAIL fair_ready_pulses: got %0d want 1", ready_cnt); end
    endtask

    task automatic test_garp_merge();
        logic [511:0] d; logic [1:0] k; bit ok;
        logic [479:0] ef;
        int extra;
        do_reset();
        pulse_rx(48'h112233445566, 32'hC0A80102);
        @(negedge clk);
        checks++; if (v512 !== 1'b1) begin errors++;
            $display("FAIL garp_reply_started: got %b want 1", v512); end
        for (int i = 0; i < 3; i++) begin
            garp_trig = 1'b1; @(negedge clk); garp_trig = 1'b0; @(negedge clk);
        end
        tready = 1'b1;
        get_frame512(d, k, ok);
        checks++; if (!ok || k !== 2'd0) begin errors++;
            $display("FAIL garp_first_reply: got ok %b kind %0d want 1 0", ok, k); end
        get_frame512(d, k, ok);
        ef = exp_frame(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'hC0A8010B);
        checks++; if (!ok || k !== 2'd2 || d[479:0] !== ef) begin errors++;
            $display("FAIL garp_frame: got ok %b kind %0d data %h want %h", ok, k, d[479:0], ef); end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            if (v512 || done512) extra++;
            @(negedge clk);
        end
        checks++; if (extra != 0) begin errors++;
            $display("FAIL garp_merged: got %0d extra active cycles want 0", extra); end
    endtask

    task automatic test_reset_midframe();
        logic [511:0] got;
        logic [479:0] ef;
        int  beat, seen;
        bit  finished;
        do_reset();
        tready = 1'b1;
        pulse_rx(48'h665544332211, 32'hC0A80103);
        @(negedge clk);
        checks++; if (v256 !== 1'b1 || l256 !== 1'b0) begin errors++;
            $display("FAIL rst256_beat0: got valid %b last %b want 1 0", v256, l256); end
        @(negedge clk);
        checks++; if (v256 !== 1'b1 || l256 !== 1'b1) begin errors++;
            $display("FAIL rst256_beat1: got valid %b last %b want 1 1", v256, l256); end
        rstn = 1'b0;
        #1;
        checks++; if (v256 !== 1'b0) begin errors++;
            $display("FAIL rst256_async_drop: got %b want 0", v256); end
        seen = 0;
        repeat (3) begin @(negedge clk); if (done256) seen++; end
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (done256 || v256) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0 || drop256 !== 16'd0) begin errors++;
            $display("FAIL rst256_quiet: got %0d active cycles drop %0d want 0 0", seen, drop256); end
        pulse_rx(48'h0A0B0C0D0E0F, 32'hC0A80104);
        got = '0; beat = 0; finished = 1'b0;
        for (int c = 0; c < 20 && !finished; c++) begin
            #1;
            if (done256) begin
                finished = 1'b1;
                checks++; if (beat != 2 || kind256 !== 2'd0) begin errors++;
                    $display("FAIL rst256_done: got beats %0d kind %0d want 2 0", beat, kind256); end
            end else if (v256) begin
                checks++; if (k256 !== ((beat == 1) ? 32'h0FFF_FFFF : 32'hFFFF_FFFF) || l256 !== (beat == 1))
                begin errors++;
                    $display("FAIL rst256_keep_last beat %0d: got %h %b", beat, k256, l256); end
                if (beat < 2) got[256*beat +: 256] = d256;
                beat++;
            end
            @(negedge clk);
        end
        checks++; if (!finished) begin errors++;
            $display("FAIL rst256_timeout: got no done want done"); end
        ef = exp_frame(48'h0A0B0C0D0E0F, 16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80104);
        checks++; if (got[479:0] !== ef) begin errors++;
            $display("FAIL rst256_frame: got %h want %h", got[479:0], ef); end
    endtask

    initial begin
        test_reset();
        test_reply_512();
        test_request_64();
        test_fifo_overflow();
        test_fairness();
        test_garp_merge();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arp_tx_mc.md
Name: arp_tx_mc

Overview:
Parametrised ARP frame transmitter for one RoCE/Ethernet channel of the data-processing board.
- Builds ARP replies in synthesis, queued from the RX ARP parser.
- Builds host-initiated ARP requests and gratuitous ARPs.
- Serialises each 60-byte frame onto an AXI4-Stream master of configurable width, one or more beats.
- Sits between the RX packet classifier and the TX arbiter in front of the MAC; CRC is appended downstream.

Parameters:
- CHANNEL_NUM, 0: added to cfg_local_mac and cfg_local_ip to form the effective channel MAC/IP; 48-bit and 32-bit adds, wrap.
- C_AXIS_DATA_WIDTH, 512: output width; legal values 64, 128, 256, 512.
- REPLY_FIFO_DEPTH, 4: pending-reply entries; power of 2, at least 2.

Ports:
- clk  in  1  core clock
- rstn  in  1  reset
- cfg_local_mac  in  48  base local MAC
- cfg_local_ip  in  32  base local IPv4
- rx_req_valid  in  1  one-cycle pulse: an ARP request addressed to us was received
- rx_req_mac  in  48  requester MAC (SHA)
- rx_req_ip  in  32  requester IP (SPA)
- tx_req_valid  in  1  host wants to resolve an IP
- tx_req_ip  in  32  target IP
- tx_req_ready  out  1  request accepted when valid and ready are both high
- garp_trig  in  1  pulse: send a gratuitous ARP
- tx_m_axis_tdata  out  C_AXIS_DATA_WIDTH  frame data; byte 0 on bits [7:0]
- tx_m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  byte enables
- tx_m_axis_tvalid  out  1
- tx_m_axis_tlast  out  1
- tx_m_axis_tready  in  1
- arp_tx_done  out  1  one-cycle pulse after the last beat is accepted
- arp_tx_kind  out  2  kind of the completed frame: 0 reply, 1 request, 2 gratuitous; valid with arp_tx_done
- reply_drop_cnt  out  16  saturating count of dropped reply requests

Reset rstn is asynchronous, active-low; clock is clk.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, garp pending cleared, last_was_reply=0. Reset mid-frame drops tvalid immediately; the partial frame is abandoned.
- Frame layout (byte offsets):
  - 0-5 DA, 6-11 SA = effective MAC, 12-13 0x0806, 14-15 0x0001, 16-17 0x0800, 18 0x06, 19 0x04.
  - 20-21 OPER, 22-27 SHA = effective MAC, 28-31 SPA = effective IP, 32-37 THA, 38-41 TPA, 42-59 zero.
- Frame contents by kind:
  - Reply: DA = THA = rx_req_mac, OPER 2, TPA = rx_req_ip.
  - Request: DA = FF:FF:FF:FF:FF:FF, OPER 1, THA = 0, TPA = tx_req_ip.
  - Gratuitous: DA broadcast, OPER 1, THA = 0, TPA = effective IP.
- Beats: NBEATS = ceil(60/(W/8)), giving 1/2/4/8 beats for W = 512/256/128/64.
  - Non-last beats: tkeep all ones.
  - Last beat: tkeep has the low (60 - (NBEATS-1)*W/8) bits set, i.e. 60/28/12/4 bytes.
  - tlast only on the last beat.
- FSM states:
  - IDLE: select a source. Selected request data and cfg are latched into a 480-bit frame register on the exit edge. Go to SEND.
  - SEND: tvalid=1. Beat counter advances only on tvalid&&tready. Data, keep and last stay stable while stalled. Last beat accepted -> DONE.
  - DONE: arp_tx_done=1 and arp_tx_kind driven for 1 cycle -> IDLE.
- Latency: a source is selectable in IDLE at cycle n; first tvalid at n+1. Minimum gap between frames is 2 cycles (DONE, IDLE).
- Selection in IDLE:
  - Reply if the FIFO is non-empty and (no tx_req_valid or last_was_reply=0).
  - Else request if tx_req_valid.
  - Else gratuitous if pending.
  - last_was_reply is set on reply selection and cleared on request selection, so requests are never starved.
- tx_req_ready is asserted only in IDLE, on the cycle the request is selected.
- Gratuitous: garp_trig sets a sticky pending flag, cleared on selection. Triggers while pending merge into one frame.
- Reply FIFO:
  - Push on rx_req_valid; pop on reply selection.
  - A push into a full FIFO is accepted if a pop occurs the same cycle; otherwise it is dropped and reply_drop_cnt increments, saturating at 0xFFFF.
  - A push into an empty FIFO is selectable the next cycle (no same-cycle bypass).
- cfg_local_* changes mid-frame do not affect the frame in flight.

Decomposition:
- Package arp_pkg:
  - ETH_TYPE_ARP, HTYPE_ETH, PTYPE_IPV4, OPER_REQ, OPER_REP, ARP_PKT_LEN=60.
  - Byte-offset localparams.
  - typedef enum arp_kind_e {ARP_REPLY, ARP_REQUEST, ARP_GARP}.
  - Frame-build function returning the 480-bit little-endian frame.
- Sub-module arp_reply_fifo: synchronous FIFO, 80-bit entries {mac, ip}, REPLY_FIFO_DEPTH deep, full/empty flags, same-cycle push/pop when full.

Test Plan:
- W=512, CHANNEL_NUM=1, cfg MAC 00:0A:35:00:00:10, IP 192.168.1.10; rx_req from MAC 11:22:33:44:55:66, IP 192.168.1.2; tready=1.
  -> One beat: DA 11:22:33:44:55:66, SA ...:11, OPER 0002, SPA C0A8010B, tkeep 64'h0FFF_FFFF_FFFF_FFFF, tlast=1, done with kind 0.
- W=64, tx_req_ip C0A80105, tready toggling 1/0 every cycle.
  -> 8 beats, data stable while stalled; last tkeep 8'h0F; beat 0 = FF×6 + SA bytes 6-7; done with kind 1.
- 6 rx_req pulses back-to-back, depth 4, downstream stalled.
  -> 4 queued, reply_drop_cnt=2; 4 replies emitted in arrival order.
- FIFO holding 3 replies with tx_req_valid held high.
  -> Order: reply, request, reply, reply; tx_req_ready pulses exactly once.
- 3 garp_trig pulses during a reply frame.
  -> Exactly one gratuitous frame after it: TPA = SPA, DA broadcast, kind 2.
- W=256, rstn asserted during beat 1 of 2.
  -> tvalid drops immediately; no done pulse; after release, FIFO empty and the next rx_req produces a correct 2-beat frame with last tkeep 32'h0FFF_FFFF.
